// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Holds the FSM state encoding, ACK/NACK levels, bit-counter constants and the majority helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX_BYTE  = 3'd3,
        RX_ACK   = 3'd4,
        TX_BYTE  = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int                   BIT_CNT_W     = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ZERO  = 4'd0;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE   = 4'd1;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST  = 4'd7;
    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;

    function automatic logic majority3(input logic [2:0] samples);
        return (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall strobes for one bus line.
// Macro I2C_TARGET_GLITCH_FILTER_EN inserts a 3-sample majority filter (2 clk extra latency).
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       level_s;

    // Metastability synchronizer; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    // Sample history; a single-sample pulse never wins the 2-of-3 vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    assign level_s = majority3(hist_q);
`else
    assign level_s = sync_q[1];
`endif

    // Previous level for edge strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_s;
        end
    end

    assign level_o = level_s;
    assign rise_o  = level_s & ~prev_q;
    assign fall_o  = ~level_s & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target (no clock stretching) with byte-wide rx/tx handshakes.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN enables the input glitch filter in i2c_sync_edge.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    i2c_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [6:0]           tx_q, tx_d;
    logic                 rw_q, rw_d;
    logic                 mack_q, mack_d;
    logic                 sda_oe_q, sda_oe_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_req_q, tx_req_d;
    logic                 busy_q, busy_d;

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_sync_edge u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (scl),
        .level_o (scl_lvl_s),
        .rise_o  (scl_rise_s),
        .fall_o  (scl_fall_s)
    );

    i2c_sync_edge u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (sda),
        .level_o (sda_lvl_s),
        .rise_o  (sda_rise_s),
        .fall_o  (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_lvl_s;
    assign stop_s  = sda_rise_s & scl_lvl_s;

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

    // Bus protocol FSM: bits sampled on SCL rise, SDA drive changes only on SCL fall.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = BIT_CNT_ZERO;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_ONE;
                    end else if (scl_fall_s && (bit_cnt_q == BITS_PER_BYTE)) begin
                        rw_d = shift_q[0];
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = BIT_CNT_ZERO;
                        if (rw_q) begin
                            state_d  = TX_BYTE;
                            tx_d     = tx_data[6:0];
                            sda_oe_d = ~tx_data[7];
                            tx_req_d = 1'b1;
                        end else begin
                            state_d  = RX_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        sda_oe_d = 1'b1;
                    end
                end
                RX_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_ONE;
                        if (bit_cnt_q == BIT_CNT_LAST) begin
                            rx_data_d  = {shift_q[6:0], sda_lvl_s};
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b0;
                        end
                    end else if (scl_fall_s && (bit_cnt_q == BITS_PER_BYTE)) begin
                        state_d  = RX_ACK;
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                RX_ACK: begin
                    if (scl_fall_s) begin
                        state_d   = RX_BYTE;
                        bit_cnt_d = BIT_CNT_ZERO;
                        sda_oe_d  = 1'b0;
                    end else begin
                        sda_oe_d = 1'b1;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_ONE;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            state_d  = TX_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end else begin
                        state_d = TX_BYTE;
                    end
                end
                TX_ACK: begin
                    if (scl_rise_s) begin
                        mack_d = sda_lvl_s;
                    end else if (scl_fall_s) begin
                        if (mack_q == ACK) begin
                            state_d   = TX_BYTE;
                            bit_cnt_d = BIT_CNT_ZERO;
                            tx_d      = tx_data[6:0];
                            sda_oe_d  = ~tx_data[7];
                            tx_req_d  = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                IDLE, IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
        busy_d = !(state_d inside {IDLE, IGNORE, ADDR});
    end

    // State and output registers; asynchronous reset releases SDA immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= BIT_CNT_ZERO;
            shift_q    <= 8'h00;
            tx_q       <= 7'h00;
            rw_q       <= 1'b0;
            mack_q     <= NACK;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master drives SCL/SDA with a pull-up on SDA.
// Define I2C_TARGET_GLITCH_FILTER_EN to also exercise the SCL glitch case.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam time Q = 40;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int LAT_LIM = 65;
`else
    localparam int LAT_LIM = 45;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    int  checks = 0;
    int  errors = 0;
    int  rx_cnt = 0;
    int  tx_cnt = 0;
    time rv_time = 0;
    time last_rise = 0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rv_time <= $time;
        end
        if (tx_req) begin
            tx_cnt <= tx_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #(2*Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; #Q;
        scl = 1'b1;
        last_rise = $time;
        #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        b = sda;      #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic [2:0] part;
        int         rc0;
        int         tc0;

        reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        #20;
        check("rst_sda", int'(sda), 32'd1);
        check("rst_busy", int'(busy), 32'd0);
        check("rst_rx_valid", int'(rx_valid), 32'd0);
        check("rst_tx_req", int'(tx_req), 32'd0);
        check("rst_rx_data", int'(rx_data), 32'h00);
        reset = 1'b0;
        #40;

        // Write 0xA5 to our address.
        rc0 = rx_cnt;
        i2c_start();
        wr_byte(8'h54, a);
        check("wr_addr_ack", int'(a), 32'd0);
        check("wr_busy", int'(busy), 32'd1);
        wr_byte(8'hA5, a);
        check("wr_data_ack", int'(a), 32'd0);
        check("rx_valid_latency", int'((rv_time - last_rise) <= LAT_LIM), 32'd1);
        i2c_stop();
        check("wr_rx_data", int'(rx_data), 32'hA5);
        check("wr_rx_pulses", rx_cnt - rc0, 32'd1);
        check("wr_busy_after_stop", int'(busy), 32'd0);

        // Wrong address: no ACK, never busy.
        rc0 = rx_cnt;
        i2c_start();
        wr_byte(8'h56, a);
        check("miss_ack_slot_high", int'(a), 32'd1);
        check("miss_busy", int'(busy), 32'd0);
        wr_byte(8'h00, a);
        check("miss_data_slot_high", int'(a), 32'd1);
        i2c_stop();
        check("miss_busy_after_stop", int'(busy), 32'd0);
        check("miss_rx_pulses", rx_cnt - rc0, 32'd0);
        check("miss_rx_data_kept", int'(rx_data), 32'hA5);

        // Read two bytes, master ACK then NACK.
        tc0 = tx_cnt;
        tx_data = 8'h3C;
        i2c_start();
        wr_byte(8'h55, a);
        check("rd_addr_ack", int'(a), 32'd0);
        check("rd_busy", int'(busy), 32'd1);
        rd_byte(d);
        check("rd_byte0", int'(d), 32'h3C);
        tx_data = 8'hC3;
        send_bit(1'b0);
        rd_byte(d);
        check("rd_byte1", int'(d), 32'hC3);
        send_bit(1'b1);
        check("rd_busy_after_nack", int'(busy), 32'd0);
        i2c_stop();
        check("rd_tx_pulses", tx_cnt - tc0, 32'd2);

        // Write then repeated START into a read.
        rc0 = rx_cnt;
        tc0 = tx_cnt;
        i2c_start();
        wr_byte(8'h54, a);
        check("rs_addr_ack", int'(a), 32'd0);
        wr_byte(8'h11, a);
        check("rs_data_ack", int'(a), 32'd0);
        i2c_start();
        check("rs_rx_data", int'(rx_data), 32'h11);
        check("rs_rx_pulses", rx_cnt - rc0, 32'd1);
        tx_data = 8'h77;
        wr_byte(8'h55, a);
        check("rs_rd_addr_ack", int'(a), 32'd0);
        rd_byte(d);
        check("rs_rd_byte", int'(d), 32'h77);
        send_bit(1'b1);
        i2c_stop();
        check("rs_tx_pulses", tx_cnt - tc0, 32'd1);

        // Reset while the target drives a 0 data bit.
        tx_data = 8'h00;
        i2c_start();
        wr_byte(8'h55, a);
        check("mr_addr_ack", int'(a), 32'd0);
        for (int i = 2; i >= 0; i--) recv_bit(part[i]);
        check("mr_part_bits", int'(part), 32'd0);
        check("mr_target_drives", int'(sda), 32'd0);
        reset = 1'b1;
        #1;
        check("mr_sda_released", int'(sda), 32'd1);
        check("mr_busy", int'(busy), 32'd0);
        check("mr_rx_data", int'(rx_data), 32'h00);
        #19;
        reset = 1'b0;
        #20;
        i2c_start();
        wr_byte(8'h54, a);
        check("mr_restart_ack", int'(a), 32'd0);
        wr_byte(8'h5A, a);
        check("mr_restart_data_ack", int'(a), 32'd0);
        i2c_stop();
        check("mr_rx_data_after", int'(rx_data), 32'h5A);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-clk SCL glitch in the low phase of bit 4.
        rc0 = rx_cnt;
        d = 8'h96;
        i2c_start();
        wr_byte(8'h54, a);
        check("gl_addr_ack", int'(a), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~d[i];
            if (i == 4) begin
                #10 scl = 1'b1;
                #10 scl = 1'b0;
                #20;
            end else begin
                #Q;
            end
            scl = 1'b1; #(2*Q);
            scl = 1'b0; #Q;
        end
        recv_bit(a);
        check("gl_data_ack", int'(a), 32'd0);
        i2c_stop();
        check("gl_rx_data", int'(rx_data), 32'h96);
        check("gl_rx_pulses", rx_cnt - rc0, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: TARGET_ADDR, default 7'h2A, 7-bit bus address this target answers to.
REQ-002 Port: clk  input  1  system clock, frequency at least 8x SCL frequency, unrelated to SCL.
REQ-003 Port: reset  input  1  asynchronous, active-high; clock clk.
REQ-004 Port: scl  input  1  I2C clock from the bus master; asynchronous to clk.
REQ-005 Port: sda  inout  1  open-drain; driven 0 when sda_oe=1, high-Z otherwise; never driven 1.
REQ-006 Port: tx_data  input  8  byte returned to the master on a read; sampled when tx_req pulses.
REQ-007 Port: rx_data  output  8  last byte written by the master.
REQ-008 Port: rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 Port: tx_req  output  1  one-clk pulse when tx_data is captured into the shift register.
REQ-010 Port: busy  output  1  high from an address match until STOP or START.

Function
REQ-011 scl and sda pass through 2-flop synchronizers; all bus events use the synchronized values only.
REQ-012 START: sync SDA falls while sync SCL is high; STOP: sync SDA rises while sync SCL is high.
REQ-013 Bits are sampled on sync SCL rising edges; sda_oe changes only on sync SCL falling edges.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE.
REQ-015 IDLE->ADDR on START; ADDR shifts 8 bits, MSB first: 7-bit address, then R/W.
REQ-016 Address match -> ADDR_ACK: drive SDA low for the 9th clock, set busy; mismatch -> IGNORE with SDA released.
REQ-017 R/W=0: ADDR_ACK->RX_BYTE; after the 8th bit, rx_data is loaded and rx_valid pulses; RX_ACK drives ACK; then back to RX_BYTE.
REQ-018 R/W=1: tx_data is captured and tx_req pulses on the SCL fall ending ADDR_ACK; TX_BYTE drives 8 bits MSB first, releasing SDA for 1s.
REQ-019 TX_ACK releases SDA and samples the master's ACK: 0 -> capture next tx_data, pulse tx_req, TX_BYTE; 1 (NACK) -> IGNORE.
REQ-020 STOP in any state -> IDLE; START in any state -> ADDR (repeated start); partial bytes are discarded and rx_valid is not pulsed.
REQ-021 rx_valid asserts no later than 4 clk after the 8th SCL rising edge at the pin.
REQ-022 sda_oe is 0 in IDLE, in IGNORE and on every 1 bit; the target never holds SCL low (no clock stretching).
REQ-023 busy falls in the same cycle the FSM enters IDLE or IGNORE.

Reset
REQ-024 Reset forces the FSM to IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, and the synchronizers to 1.
REQ-025 Reset mid-transfer releases SDA immediately (asynchronous); the next transfer requires a fresh START.

Configuration
REQ-026 Macro I2C_TARGET_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer, adding 2 clk latency; pulses of 1 clk or shorter are rejected.
REQ-027 Macro undefined: no filter; latency is as in REQ-021.

Structure
REQ-028 Package i2c_pkg holds the FSM state typedef, ACK=1'b0 and NACK=1'b1 constants, and the bit-count width constant.
REQ-029 Sub-module i2c_sync_edge: synchronizer, optional filter, and rise/fall strobes; instantiated once for scl and once for sda.

Verification
REQ-030 START, addr 0x2A W, data 0xA5, STOP -> target ACKs twice; rx_data=0xA5; exactly one rx_valid pulse.
REQ-031 START, addr 0x2B W -> SDA never low during the ACK slot; busy stays 0; STOP -> IDLE.
REQ-032 START, addr 0x2A R, tx_data=0x3C then 0xC3, master ACK then NACK, STOP -> bus bytes 0x3C, 0xC3; two tx_req pulses.
REQ-033 Write 0x11, then repeated START with addr 0x2A R -> rx_data=0x11, then a read proceeds without a STOP.
REQ-034 Reset asserted mid data byte -> sda_oe=0 within the same cycle; STOP-free restart with START, addr 0x2A W succeeds.
REQ-035 With I2C_TARGET_GLITCH_FILTER_EN, a 1-clk SCL glitch mid-byte -> bit count unchanged and the received byte is correct.
